// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared defaults and types for the key debounce block
package key_pkg;
    localparam int N_KEYS_DEFAULT          = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;

    typedef logic [N_KEYS_DEFAULT-1:0] key_vec_t;
endpackage

// File: rtl/key_debounce_bit.sv
// rtl/key_debounce_bit.sv - one key channel: synchroniser, stability counter, strobes, toggle
import key_pkg::*;

module key_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_next,
    output logic pressed,
    output logic released,
    output logic toggle
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             rise;
    logic             fall;

    always_comb begin
        cnt_next    = cnt;
        stable_next = stable;
        rise        = 1'b0;
        fall        = 1'b0;
        if (sync2 == stable) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            // The D-th consecutive mismatching edge commits the new level.
            cnt_next    = '0;
            stable_next = sync2;
            rise        = sync2;
            fall        = ~sync2;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            stable   <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            cnt      <= cnt_next;
            stable   <= stable_next;
            pressed  <= rise;
            released <= fall;
            toggle   <= toggle ^ rise;
        end
    end
endmodule

// File: rtl/key_debounce_sync.sv
// rtl/key_debounce_sync.sv - N independent debounced key channels plus registered any_pressed
import key_pkg::*;

module key_debounce_sync #(
    parameter int N_KEYS          = N_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_stable,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] key_released,
    output logic [N_KEYS-1:0] key_toggle,
    output logic              any_pressed
);
    logic [N_KEYS-1:0] stable_next;

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
            $error("key_debounce_sync: DEBOUNCE_CYCLES must be >= 2");
        end
    endgenerate

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clock       (clock),
            .reset       (reset),
            .raw         (key_raw[i]),
            .stable      (key_stable[i]),
            .stable_next (stable_next[i]),
            .pressed     (key_pressed[i]),
            .released    (key_released[i]),
            .toggle      (key_toggle[i])
        );
    end

    // Built from next-state levels so it lands on the same edge as key_stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_pressed <= 1'b0;
        end else begin
            any_pressed <= |stable_next;
        end
    end
endmodule
